// File: rtl/cpu_writeback_stage.sv
// Writeback stage: registers committed ALU results or returned load data and
// drives the register-file write port and the writeback bypass. It also tracks
// one outstanding load against data memory and stalls commit while it waits.
module cpu_writeback_stage #(
    parameter int unsigned REG_WIDTH = 32,
    parameter int unsigned NUM_REGS  = 32,
    localparam int unsigned IDX_W    = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 commit_valid,
    input  logic [IDX_W-1:0]     commit_rd,
    input  logic                 commit_we,
    input  logic                 commit_is_load,
    input  logic                 commit_load_byte,
    input  logic [1:0]           commit_addr_lo,
    input  logic [REG_WIDTH-1:0] commit_value,
    input  logic                 flush,
    input  logic                 mem_rsp_valid,
    input  logic [REG_WIDTH-1:0] mem_rsp_data,
    output logic                 stall_commit,
    output logic [IDX_W-1:0]     rd_wb,
    output logic [REG_WIDTH-1:0] wb_value,
    output logic                 writeback_wb,
    output logic [31:0]          retire_count,
    output logic                 err_spurious
);

    typedef enum logic [1:0] {StIdle, StWaitMem, StDrain} state_e;

    state_e state;

    // Fields of the outstanding load
    logic [IDX_W-1:0] ld_rd;
    logic             ld_we;
    logic             ld_byte;
    logic [1:0]       ld_lo;

    // One-entry skid: holds an instruction accepted in the same cycle as a
    // load response, so it writes back the cycle after the load.
    logic                 pend_valid;
    logic [IDX_W-1:0]     pend_rd;
    logic [REG_WIDTH-1:0] pend_value;
    logic                 pend_we;

    // Word loads pass through; byte loads select a little-endian lane, zero-extended.
    function automatic logic [REG_WIDTH-1:0] fmt_load(input logic [REG_WIDTH-1:0] data,
                                                      input logic is_byte,
                                                      input logic [1:0] lo);
        logic [7:0] lane;
        lane = data[{lo, 3'b000} +: 8];
        if (is_byte) begin
            return {{(REG_WIDTH-8){1'b0}}, lane};
        end
        return data;
    endfunction

    logic                 accept;
    logic                 take_new;
    logic                 new_done;
    logic                 new_load_wait;
    logic [REG_WIDTH-1:0] new_value;
    logic                 new_we;
    logic                 load_done;
    logic [REG_WIDTH-1:0] load_value;
    logic                 load_we;
    logic                 out_fire;
    logic [IDX_W-1:0]     out_rd;
    logic [REG_WIDTH-1:0] out_value;
    logic                 out_we;
    logic                 pend_valid_d;
    state_e               state_d;
    logic                 spurious;

    // Stall and per-cycle completion decode
    always_comb begin
        stall_commit  = (state != StIdle) && !(state == StWaitMem && mem_rsp_valid);
        accept        = commit_valid && !stall_commit;
        take_new      = accept && !flush;
        // In WAIT_MEM a response belongs to the older load, never the new one
        new_done      = take_new && (!commit_is_load || (state == StIdle && mem_rsp_valid));
        new_load_wait = take_new && commit_is_load && !(state == StIdle && mem_rsp_valid);
        new_value     = commit_is_load ? fmt_load(mem_rsp_data, commit_load_byte, commit_addr_lo)
                                       : commit_value;
        new_we        = commit_we && (commit_rd != '0);
        load_done     = (state == StWaitMem) && mem_rsp_valid && !flush;
        load_value    = fmt_load(mem_rsp_data, ld_byte, ld_lo);
        load_we       = ld_we && (ld_rd != '0);
        spurious      = mem_rsp_valid && (state == StIdle) && !(accept && commit_is_load);
    end

    // Writeback source in age order: skid entry, then load, then new instruction
    always_comb begin
        out_fire     = pend_valid || load_done || new_done;
        out_rd       = commit_rd;
        out_value    = new_value;
        out_we       = new_we;
        if (pend_valid) begin
            out_rd    = pend_rd;
            out_value = pend_value;
            out_we    = pend_we;
        end else if (load_done) begin
            out_rd    = ld_rd;
            out_value = load_value;
            out_we    = load_we;
        end
        pend_valid_d = (pend_valid || load_done) && new_done;
    end

    // Next load-tracking state
    always_comb begin
        state_d = state;
        unique case (state)
            StIdle: begin
                if (new_load_wait) state_d = StWaitMem;
            end
            StWaitMem: begin
                if (mem_rsp_valid) begin
                    state_d = new_load_wait ? StWaitMem : StIdle;
                end else if (flush) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (mem_rsp_valid) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State, load capture, skid entry and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= StIdle;
            ld_rd        <= '0;
            ld_we        <= 1'b0;
            ld_byte      <= 1'b0;
            ld_lo        <= 2'b00;
            pend_valid   <= 1'b0;
            pend_rd      <= '0;
            pend_value   <= '0;
            pend_we      <= 1'b0;
            rd_wb        <= '0;
            wb_value     <= '0;
            writeback_wb <= 1'b0;
            retire_count <= 32'd0;
            err_spurious <= 1'b0;
        end else begin
            state      <= state_d;
            pend_valid <= pend_valid_d;
            if (new_load_wait) begin
                ld_rd   <= commit_rd;
                ld_we   <= commit_we;
                ld_byte <= commit_load_byte;
                ld_lo   <= commit_addr_lo;
            end
            if (pend_valid_d) begin
                pend_rd    <= commit_rd;
                pend_value <= new_value;
                pend_we    <= new_we;
            end
            writeback_wb <= out_fire && out_we;
            if (out_fire) begin
                rd_wb        <= out_rd;
                wb_value     <= out_value;
                retire_count <= retire_count + 32'd1;
            end
            if (spurious) err_spurious <= 1'b1;
        end
    end

endmodule
